load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit_lane_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - FSM state encoding (ST_*)
//   - access-type constants for req_funct3 (F3_*)
//   - access_err(): misalignment / illegal access-type decode, evaluated at accept
package load_store_unit_pkg;

    // FSM state encoding
    typedef logic [2:0] lsu_state_t;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RD_MOD = 3'd2;
    localparam logic [2:0] ST_WR     = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // access types carried on req_funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // 1 when the request must complete with an error and no memory access:
    // misaligned H/HU/W, unused encodings, or an unsigned type used for a store.
    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = offset[0];
            F3_W:    err = (offset != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | offset[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle between a CPU-side requester, the load/store unit and data memory.
//   req_*   : request handshake and payload (valid/ready)
//   resp_*  : one-cycle completion pulse with load data / error flag
//   mem_*   : word-aligned data memory port; mem_read_data is combinational
// Modports:
//   slave  : the load/store unit
//   master : requester + memory model (testbench or surrounding core)
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_wd, mem_we
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane handling for a big-endian 32-bit data memory
// (byte offset 0 = [31:24] ... offset 3 = [7:0]; half offset 0 = [31:16], 2 = [15:0]).
// Ports:
//   funct3     : access type (F3_*)
//   offset     : byte offset within the word (address [1:0])
//   rd_word    : word read from memory
//   wdata      : right-aligned store data
//   load_data  : addressed lane, sign- or zero-extended per funct3
//   store_word : rd_word with the addressed lane(s) replaced by wdata
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (offset)
            2'd0:    lane_b = rd_word[31:24];
            2'd1:    lane_b = rd_word[23:16];
            2'd2:    lane_b = rd_word[15:8];
            default: lane_b = rd_word[7:0];
        endcase
        lane_h = offset[1] ? rd_word[15:0] : rd_word[31:16];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        store_word = rd_word;
        case (funct3)
            F3_B: begin
                case (offset)
                    2'd0:    store_word[31:24] = wdata[7:0];
                    2'd1:    store_word[23:16] = wdata[7:0];
                    2'd2:    store_word[15:8]  = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1]) store_word[15:0]  = wdata[15:0];
                else           store_word[31:16] = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = rd_word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time and performs it against a
// big-endian, word-addressed data memory. Sub-word stores are read-modify-write.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : load_store_unit_if.slave (request, response and memory port)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | req_ready=1, waiting for a request
// ST_LOAD   | sample memory word, extract/extend addressed lane
// ST_RD_MOD | sample memory word, merge store lane(s) into it
// ST_WR     | mem_we=1 for this single cycle with the final write word
// ST_RESP   | resp_valid=1 for one cycle, then back to idle
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       load_data;
    logic [31:0]       store_word;
    logic              mem_active;

    // wd_q holds raw store data until RD_MOD, then the merged word for WR
    lsu_lane_align u_lane_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .rd_word    (bus.mem_read_data),
        .wdata      (wd_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wd_q     <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wd_q     <= bus.req_wdata;
                        rdata_q  <= 32'h0;
                        err_q    <= access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
                        if (access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]))
                            state <= ST_RESP;
                        else if (!bus.req_we)
                            state <= ST_LOAD;
                        else if (bus.req_funct3 == F3_W)
                            state <= ST_WR;
                        else
                            state <= ST_RD_MOD;
                    end
                end
                ST_LOAD: begin
                    rdata_q <= load_data;
                    state   <= ST_RESP;
                end
                ST_RD_MOD: begin
                    wd_q  <= store_word;
                    state <= ST_WR;
                end
                ST_WR:   state <= ST_RESP;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_active      = (state == ST_LOAD) || (state == ST_RD_MOD) || (state == ST_WR);

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.resp_valid  = (state == ST_RESP);
    assign bus.resp_err    = (state == ST_RESP) && err_q;
    // stores leave rdata_q at 0, so only loads return nonzero data
    assign bus.resp_rdata  = (state == ST_RESP) ? rdata_q : 32'h0;

    assign bus.mem_address = mem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wd      = (state == ST_WR) ? wd_q : 32'h0;
    assign bus.mem_we      = (state == ST_WR);

    // we_q is kept for debug visibility of the accepted request
    logic unused_we;
    assign unused_we = we_q;
endmodule
